hazard5_bus_arbiter: RTL and testbench

//  Shares one AHB-Lite master port between the Hazard5 core's instruction-fetch and load/store interfaces.

---
 rtl/hazard5_bus_arbiter_pkg.sv | 25 ++
 rtl/hazard5_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_hazard5_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard5_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// hazard5_bus_arbiter_pkg
// Purpose : Shared AHB-Lite encodings and the data-phase owner type used by
//           the Hazard5 single-port bus arbiter.
// Contents: HTRANS_IDLE/HTRANS_NSEQ, HPROT_DATA/HPROT_OPCODE, dph_owner_t.
// -----------------------------------------------------------------------------
package hazard5_bus_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE  = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ  = 2'b10;

  // Privileged, non-cacheable, non-bufferable; bit 0 separates data from opcode.
  localparam logic [3:0] HPROT_DATA   = 4'b0011;
  localparam logic [3:0] HPROT_OPCODE = 4'b0010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Which requester owns the AHB data phase currently in flight.
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } dph_owner_t;

endpackage

// File: rtl/hazard5_bus_arbiter.sv
// -----------------------------------------------------------------------------
// hazard5_bus_arbiter
// Purpose : Shares one AHB-Lite master port between the Hazard5 instruction
//           fetch (I) and load/store (D) interfaces. One address phase is
//           granted per cycle; the owner of the data phase in flight is
//           tracked so that ready/error/write data are routed to it only.
// Ports   :
//   clk, rst_n                 clock, asynchronous active-low reset
//   aph_req_i, aph_panic_i     fetch request / fetch starvation escalation
//   haddr_i, hsize_i           fetch address phase fields
//   aph_ready_i                fetch address phase accepted this cycle
//   dph_ready_i, dph_err_i     fetch data phase complete / complete with error
//   rdata_i                    fetch read data
//   aph_req_d                  load/store request
//   haddr_d, hsize_d, hwrite_d load/store address phase fields
//   wdata_d                    store data (valid during D's data phase)
//   aph_ready_d                load/store address phase accepted
//   dph_ready_d, dph_err_d     load/store data phase complete / error
//   rdata_d                    load read data
//   haddr..hmastlock, hwdata   AHB-Lite master outputs
//   hready, hresp, hrdata      AHB-Lite slave response
// -----------------------------------------------------------------------------
module hazard5_bus_arbiter
  import hazard5_bus_arbiter_pkg::*;
#(
  parameter int W_ADDR         = 32,
  parameter int W_DATA         = 32,
  parameter int FAIRNESS_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // Instruction fetch
  input  logic              aph_req_i,
  input  logic              aph_panic_i,
  input  logic [W_ADDR-1:0] haddr_i,
  input  logic [2:0]        hsize_i,
  output logic              aph_ready_i,
  output logic              dph_ready_i,
  output logic              dph_err_i,
  output logic [W_DATA-1:0] rdata_i,
  // Load/store
  input  logic              aph_req_d,
  input  logic [W_ADDR-1:0] haddr_d,
  input  logic [2:0]        hsize_d,
  input  logic              hwrite_d,
  input  logic [W_DATA-1:0] wdata_d,
  output logic              aph_ready_d,
  output logic              dph_ready_d,
  output logic              dph_err_d,
  output logic [W_DATA-1:0] rdata_d,
  // AHB-Lite master
  output logic [W_ADDR-1:0] haddr,
  output logic              hwrite,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic              hmastlock,
  output logic [W_DATA-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [W_DATA-1:0] hrdata
);

  // A limit of 0 still needs a 1-bit counter to keep the declarations legal;
  // it then never leaves zero.
  localparam int W_CNT = (FAIRNESS_LIMIT > 0) ? $clog2(FAIRNESS_LIMIT + 1) : 1;
  localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(FAIRNESS_LIMIT);

  dph_owner_t       r_owner;
  dph_owner_t       w_owner_next;
  logic [W_CNT-1:0] r_starve_cnt;
  logic [W_CNT-1:0] w_starve_next;

  logic w_force_i;
  logic w_gnt_i;
  logic w_gnt_d;

  // ---------------------------------------------------------------------------
  // Address-phase grant (combinational). D wins by default; I wins when it
  // panics or has watched D take FAIRNESS_LIMIT consecutive grants.
  // ---------------------------------------------------------------------------
  assign w_force_i = (FAIRNESS_LIMIT != 0) && (r_starve_cnt == CNT_MAX);
  assign w_gnt_d   = aph_req_d && !(aph_req_i && (aph_panic_i || w_force_i));
  assign w_gnt_i   = aph_req_i && !w_gnt_d;

  assign aph_ready_i = hready && w_gnt_i;
  assign aph_ready_d = hready && w_gnt_d;

  // When idle the D fields are selected, but hwrite is still forced low so an
  // IDLE transfer never looks like a write.
  assign htrans    = (aph_req_i || aph_req_d) ? HTRANS_NSEQ : HTRANS_IDLE;
  assign haddr     = w_gnt_i ? haddr_i : haddr_d;
  assign hsize     = w_gnt_i ? hsize_i : hsize_d;
  assign hwrite    = w_gnt_d && hwrite_d;
  assign hprot     = w_gnt_i ? HPROT_OPCODE : HPROT_DATA;
  assign hburst    = HBURST_SINGLE;
  assign hmastlock = 1'b0;

  // ---------------------------------------------------------------------------
  // Data-phase owner and starvation counter: both advance only when the bus
  // accepts the current address phase (hready high).
  // ---------------------------------------------------------------------------
  always_comb begin
    w_owner_next  = r_owner;
    w_starve_next = r_starve_cnt;
    if (hready) begin
      if (w_gnt_i)      w_owner_next = OWNER_I;
      else if (w_gnt_d) w_owner_next = OWNER_D;
      else              w_owner_next = OWNER_NONE;

      if (w_gnt_i || !aph_req_i)
        w_starve_next = '0;
      else if (r_starve_cnt != CNT_MAX)
        // aph_req_i && !w_gnt_i implies D took the grant over a waiting I.
        w_starve_next = r_starve_cnt + W_CNT'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= OWNER_NONE;
      r_starve_cnt <= '0;
    end else begin
      r_owner      <= w_owner_next;
      r_starve_cnt <= w_starve_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Data-phase response routing. The first cycle of a two-cycle AHB error
  // (hready low) is masked by the hready qualifier, giving a single pulse.
  // ---------------------------------------------------------------------------
  assign dph_ready_i = hready && (r_owner == OWNER_I);
  assign dph_ready_d = hready && (r_owner == OWNER_D);
  assign dph_err_i   = hready && hresp && (r_owner == OWNER_I);
  assign dph_err_d   = hready && hresp && (r_owner == OWNER_D);

  assign rdata_i = hrdata;
  assign rdata_d = hrdata;
  assign hwdata  = (r_owner == OWNER_D) ? wdata_d : '0;

endmodule

// File: tb/tb_hazard5_bus_arbiter.sv
module tb_hazard5_bus_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aph_req_i, aph_panic_i;
  logic [31:0] haddr_i;
  logic [2:0]  hsize_i;
  logic        aph_ready_i, dph_ready_i, dph_err_i;
  logic [31:0] rdata_i;
  logic        aph_req_d;
  logic [31:0] haddr_d;
  logic [2:0]  hsize_d;
  logic        hwrite_d;
  logic [31:0] wdata_d;
  logic        aph_ready_d, dph_ready_d, dph_err_d;
  logic [31:0] rdata_d;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready, hresp;
  logic [31:0] hrdata;

  always #5 clk = ~clk;

  hazard5_bus_arbiter #(.W_ADDR(32), .W_DATA(32), .FAIRNESS_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .aph_req_i(aph_req_i), .aph_panic_i(aph_panic_i), .haddr_i(haddr_i), .hsize_i(hsize_i),
    .aph_ready_i(aph_ready_i), .dph_ready_i(dph_ready_i), .dph_err_i(dph_err_i), .rdata_i(rdata_i),
    .aph_req_d(aph_req_d), .haddr_d(haddr_d), .hsize_d(hsize_d), .hwrite_d(hwrite_d), .wdata_d(wdata_d),
    .aph_ready_d(aph_ready_d), .dph_ready_d(dph_ready_d), .dph_err_d(dph_err_d), .rdata_d(rdata_d),
    .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model: who owns the data phase (0 none, 1 fetch, 2 load/store)
  // and how many D grants in a row have been taken while fetch was waiting.
  int   m_owner  = 0;
  int   m_streak = 0;
  logic e_gi, e_gd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_grant();
    bit force_i;
    force_i = (LIM != 0) && (m_streak >= LIM);
    // Fetch wins only if it asks and either panics, is forced, or D is silent.
    e_gi = aph_req_i && (aph_panic_i || force_i || !aph_req_d);
    e_gd = aph_req_d && !e_gi;
  endtask

  // Mid-cycle: compare every output against the model.
  task automatic sample(input string tag);
    @(negedge clk);
    model_grant();
    chk({tag, " aph_ready_i"}, 64'(aph_ready_i), 64'(hready && e_gi));
    chk({tag, " aph_ready_d"}, 64'(aph_ready_d), 64'(hready && e_gd));
    chk({tag, " htrans"},      64'(htrans), (aph_req_i || aph_req_d) ? 64'h2 : 64'h0);
    chk({tag, " haddr"},       64'(haddr),  e_gi ? 64'(haddr_i) : 64'(haddr_d));
    chk({tag, " hsize"},       64'(hsize),  e_gi ? 64'(hsize_i) : 64'(hsize_d));
    chk({tag, " hwrite"},      64'(hwrite), 64'(e_gd && hwrite_d));
    chk({tag, " hprot"},       64'(hprot),  e_gi ? 64'h2 : 64'h3);
    chk({tag, " hburst"},      64'(hburst), 64'h0);
    chk({tag, " hmastlock"},   64'(hmastlock), 64'h0);
    chk({tag, " dph_ready_i"}, 64'(dph_ready_i), 64'(hready && m_owner == 1));
    chk({tag, " dph_ready_d"}, 64'(dph_ready_d), 64'(hready && m_owner == 2));
    chk({tag, " dph_err_i"},   64'(dph_err_i), 64'(hready && hresp && m_owner == 1));
    chk({tag, " dph_err_d"},   64'(dph_err_d), 64'(hready && hresp && m_owner == 2));
    chk({tag, " rdata_i"},     64'(rdata_i), 64'(hrdata));
    chk({tag, " rdata_d"},     64'(rdata_d), 64'(hrdata));
    chk({tag, " hwdata"},      64'(hwdata), (m_owner == 2) ? 64'(wdata_d) : 64'h0);
  endtask

  // Clock edge: advance the model with the inputs the DUT just sampled.
  task automatic tick();
    @(posedge clk);
    model_grant();
    if (rst_n && hready) begin
      m_owner  = e_gi ? 1 : (e_gd ? 2 : 0);
      m_streak = (aph_req_i && e_gd) ? ((m_streak + 1 > LIM) ? LIM : m_streak + 1) : 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    aph_req_i = 0; aph_panic_i = 0; haddr_i = 32'h0; hsize_i = 3'd2;
    aph_req_d = 0; haddr_d = 32'h0; hsize_d = 3'd2; hwrite_d = 0; wdata_d = 32'h0;
    hready = 1; hresp = 0; hrdata = 32'h0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    // Reset state: no data-phase response even with hready high.
    sample("reset");
    chk("reset dph_ready_i", 64'(dph_ready_i), 64'h0);
    chk("reset dph_ready_d", 64'(dph_ready_d), 64'h0);
    tick();
    rst_n = 1;

    // 1. Fetch only.
    aph_req_i = 1; haddr_i = 32'h100;
    sample("t1 aph");
    chk("t1 htrans", 64'(htrans), 64'h2);
    chk("t1 haddr", 64'(haddr), 64'h100);
    chk("t1 hprot", 64'(hprot), 64'h2);
    tick();
    aph_req_i = 0; hrdata = 32'hCAFE_0100;
    sample("t1 dph");
    chk("t1 dph_ready_i", 64'(dph_ready_i), 64'h1);
    chk("t1 rdata_i", 64'(rdata_i), 64'hCAFE_0100);
    tick();

    // 2. Both request, no panic: D first, then I.
    aph_req_i = 1; haddr_i = 32'h200; aph_req_d = 1; haddr_d = 32'h8000;
    sample("t2 c0");
    chk("t2 c0 aph_ready_d", 64'(aph_ready_d), 64'h1);
    chk("t2 c0 aph_ready_i", 64'(aph_ready_i), 64'h0);
    tick();
    aph_req_d = 0;
    sample("t2 c1");
    chk("t2 c1 aph_ready_i", 64'(aph_ready_i), 64'h1);
    chk("t2 c1 dph_ready_d", 64'(dph_ready_d), 64'h1);
    tick();
    aph_req_i = 0;
    sample("t2 c2");
    chk("t2 c2 dph_ready_i", 64'(dph_ready_i), 64'h1);
    tick();

    // 3. Both request with panic: I first, D next.
    aph_req_i = 1; aph_panic_i = 1; aph_req_d = 1;
    sample("t3 c0");
    chk("t3 c0 aph_ready_i", 64'(aph_ready_i), 64'h1);
    chk("t3 c0 aph_ready_d", 64'(aph_ready_d), 64'h0);
    tick();
    aph_req_i = 0; aph_panic_i = 0;
    sample("t3 c1");
    chk("t3 c1 aph_ready_d", 64'(aph_ready_d), 64'h1);
    tick();
    aph_req_d = 0;
    sample("t3 c2");
    tick();

    // 4. Fairness: D every cycle, I held. Four D grants, then I, then D again.
    aph_req_i = 1; aph_req_d = 1;
    for (int k = 0; k < LIM; k++) begin
      sample("t4 d");
      chk("t4 aph_ready_d", 64'(aph_ready_d), 64'h1);
      tick();
    end
    sample("t4 forced");
    chk("t4 forced aph_ready_i", 64'(aph_ready_i), 64'h1);
    tick();
    sample("t4 after");
    chk("t4 after aph_ready_d", 64'(aph_ready_d), 64'h1);
    tick();
    aph_req_i = 0; aph_req_d = 0;
    sample("t4 drain");
    tick();

    // 5. D write with three wait states.
    aph_req_d = 1; hwrite_d = 1; haddr_d = 32'h9000;
    sample("t5 aph");
    chk("t5 hwrite", 64'(hwrite), 64'h1);
    tick();
    aph_req_d = 0; hwrite_d = 0; wdata_d = 32'h1234_5678; hready = 0;
    for (int k = 0; k < 3; k++) begin
      sample("t5 wait");
      chk("t5 wait hwdata", 64'(hwdata), 64'h1234_5678);
      chk("t5 wait dph_ready_d", 64'(dph_ready_d), 64'h0);
      tick();
    end
    hready = 1;
    sample("t5 done");
    chk("t5 done dph_ready_d", 64'(dph_ready_d), 64'h1);
    tick();
    sample("t5 post");
    chk("t5 post dph_ready_d", 64'(dph_ready_d), 64'h0);
    tick();

    // 6. Two-cycle error on a fetch data phase.
    aph_req_i = 1; haddr_i = 32'h300;
    sample("t6 aph");
    tick();
    aph_req_i = 0; hready = 0; hresp = 1;
    sample("t6 err1");
    chk("t6 err1 dph_err_i", 64'(dph_err_i), 64'h0);
    tick();
    hready = 1;
    sample("t6 err2");
    chk("t6 err2 dph_err_i", 64'(dph_err_i), 64'h1);
    chk("t6 err2 dph_err_d", 64'(dph_err_d), 64'h0);
    tick();
    sample("t6 post");
    chk("t6 post dph_err_i", 64'(dph_err_i), 64'h0);
    hresp = 0;
    tick();

    // 7. Reset in the middle of a stalled D data phase.
    aph_req_d = 1;
    sample("t7 aph");
    tick();
    aph_req_d = 0; hready = 0;
    sample("t7 stall");
    #2 rst_n = 0;
    m_owner = 0; m_streak = 0;
    hready = 1;
    #1 chk("t7 in reset dph_ready_d", 64'(dph_ready_d), 64'h0);
    tick();
    rst_n = 1;
    sample("t7 release");
    chk("t7 release dph_ready_d", 64'(dph_ready_d), 64'h0);
    tick();

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      aph_req_i   = ($urandom_range(0, 3) != 0);
      aph_panic_i = ($urandom_range(0, 7) == 0);
      aph_req_d   = ($urandom_range(0, 3) != 0);
      haddr_i     = $urandom; hsize_i = 3'($urandom_range(0, 2));
      haddr_d     = $urandom; hsize_d = 3'($urandom_range(0, 2));
      hwrite_d    = 1'($urandom);
      wdata_d     = $urandom;
      hready      = ($urandom_range(0, 3) != 0);
      hresp       = ($urandom_range(0, 9) == 0);
      hrdata      = $urandom;
      sample("rand");
      tick();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
